// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared state encoding and default width for the count-run controller
package count_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int COUNT_W = 3;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot pick searching upward from a registered pointer
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   ptr
);
  logic [PW-1:0] ptr_nxt;
  // scanning from the farthest offset down leaves the nearest requester as the final winner
  always_comb begin
    pick = '0;
    ptr_nxt = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        pick = '0;
        pick[(int'(ptr) + k) % NREQ] = 1'b1;
        ptr_nxt = PW'((int'(ptr) + k + 1) % NREQ);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= ptr_nxt;
endmodule

// File: rtl/count_run_arbiter.sv
// count_run_arbiter: shares one up-counter among requesters, each running over its own [lo, hi] range
module count_run_arbiter
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = COUNT_W,
  parameter int NREQ  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][WIDTH-1:0] lo,
  input  logic [NREQ-1:0][WIDTH-1:0] hi,
  output logic [NREQ-1:0]            gnt,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic                       done,
  output logic                       busy
);
  state_t state, state_d;
  logic [NREQ-1:0] pick, gnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, out_d, sel_lo, sel_hi;
  logic out_valid_d, done_d, busy_d, advance;
  logic [$clog2(NREQ)-1:0] ptr;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .advance(advance),
    .pick(pick),
    .ptr(ptr)
  );
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    for (int k = 0; k < NREQ; k++)
      if (pick[k]) begin
        sel_lo = lo[k];
        sel_hi = hi[k];
      end
  end
  // every path not explicitly held falls back to the all-zero idle outputs
  always_comb begin
    state_d = IDLE;
    gnt_d = '0;
    out_d = '0;
    hi_d = hi_q;
    out_valid_d = 1'b0;
    done_d = 1'b0;
    busy_d = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE:
        if (|req) begin
          advance = 1'b1;
          state_d = RUN;
          gnt_d = pick;
          out_d = sel_lo;
          hi_d = sel_hi;
          out_valid_d = 1'b1;
          busy_d = 1'b1;
        end
      RUN:
        if (|(req & gnt)) begin
          gnt_d = gnt;
          busy_d = 1'b1;
          state_d = (out == hi_q) ? DONE : RUN;
          out_d = (out == hi_q) ? out : out + 1'b1;
          out_valid_d = (out != hi_q);
          done_d = (out == hi_q);
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      out <= '0;
      hi_q <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      gnt <= gnt_d;
      out <= out_d;
      hi_q <= hi_d;
      out_valid <= out_valid_d;
      done <= done_d;
      busy <= busy_d;
    end
endmodule

// File: tb/tb_count_run_arbiter.sv
// tb_count_run_arbiter: table vectors, hand-written corner sequences and a randomized run against a transaction model
module tb_count_run_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req;
  logic [1:0][2:0] lo, hi;
  logic [1:0] gnt;
  logic [2:0] out;
  logic out_valid, done, busy;
  int checks = 0;
  int errors = 0;

  count_run_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .lo(lo),
    .hi(hi),
    .gnt(gnt),
    .out(out),
    .out_valid(out_valid),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] g;
    logic [2:0] o;
    logic v;
    logic d;
    logic b;
  } exp_t;

  typedef struct {
    logic [1:0] r;
    logic [2:0] l;
    logic [2:0] h;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t q[$];
  exp_t cur;
  int mptr;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input exp_t e);
    checks++;
    if ({gnt, out, out_valid, done, busy} !== e) begin
      errors++;
      $display("FAIL %s @%0t: got gnt=%b out=%0d v=%b d=%b b=%b, want gnt=%b out=%0d v=%b d=%b b=%b",
               nm, $time, gnt, out, out_valid, done, busy, e.g, e.o, e.v, e.d, e.b);
    end
  endtask

  // transaction-level model: a grant expands into L run values, one DONE cycle and one forced IDLE cycle
  task automatic model_step();
    int w, len;
    if (q.size() > 0) cur = q.pop_front();
    else if (|req) begin
      w = req[mptr] ? mptr : (mptr + 1) % 2;
      len = ((int'(hi[w]) - int'(lo[w])) & 7) + 1;
      for (int k = 0; k < len; k++) q.push_back({2'(1 << w), 3'((int'(lo[w]) + k) & 7), 1'b1, 1'b0, 1'b1});
      q.push_back({2'(1 << w), hi[w], 1'b0, 1'b1, 1'b1});
      q.push_back(exp_t'(0));
      mptr = (w + 1) % 2;
      cur = q.pop_front();
    end else cur = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 2'b11;
    lo = '0;
    hi = '0;
    hi[0] = 3'd3;
    hi[1] = 3'd3;
    cyc();
    chk("reset_outputs", '0);
    rst_n = 1'b1;
    cyc();
    chk("first_grant_req0", {2'b01, 3'd0, 1'b1, 1'b0, 1'b1});
    req = 2'b00;
    cyc();
    chk("first_abort", '0);

    tbl.push_back('{2'b01, 3'd2, 3'd4, {2'b01, 3'd2, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd2, 3'd4, {2'b01, 3'd3, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd2, 3'd4, {2'b01, 3'd4, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd2, 3'd4, {2'b01, 3'd4, 1'b0, 1'b1, 1'b1}});
    tbl.push_back('{2'b00, 3'd2, 3'd4, {2'b00, 3'd0, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{2'b00, 3'd2, 3'd4, {2'b00, 3'd0, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{2'b01, 3'd6, 3'd1, {2'b01, 3'd6, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd0, 3'd0, {2'b01, 3'd7, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd0, 3'd0, {2'b01, 3'd0, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd0, 3'd0, {2'b01, 3'd1, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd0, 3'd0, {2'b01, 3'd1, 1'b0, 1'b1, 1'b1}});
    tbl.push_back('{2'b00, 3'd0, 3'd0, {2'b00, 3'd0, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{2'b01, 3'd5, 3'd5, {2'b01, 3'd5, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd5, 3'd5, {2'b01, 3'd5, 1'b0, 1'b1, 1'b1}});
    tbl.push_back('{2'b00, 3'd5, 3'd5, {2'b00, 3'd0, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{2'b01, 3'd2, 3'd4, {2'b01, 3'd2, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd2, 3'd7, {2'b01, 3'd3, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd2, 3'd7, {2'b01, 3'd4, 1'b1, 1'b0, 1'b1}});
    tbl.push_back('{2'b01, 3'd2, 3'd7, {2'b01, 3'd4, 1'b0, 1'b1, 1'b1}});
    tbl.push_back('{2'b00, 3'd2, 3'd7, {2'b00, 3'd0, 1'b0, 1'b0, 1'b0}});
    lo = '0;
    hi = '0;
    foreach (tbl[i]) begin
      req = tbl[i].r;
      lo[0] = tbl[i].l;
      hi[0] = tbl[i].h;
      cyc();
      chk($sformatf("table_%0d", i), tbl[i].e);
    end

    begin
      exp_t rr[9];
      rr = '{{2'b01, 3'd0, 1'b1, 1'b0, 1'b1}, {2'b01, 3'd1, 1'b1, 1'b0, 1'b1}, {2'b01, 3'd1, 1'b0, 1'b1, 1'b1},
             {2'b00, 3'd0, 1'b0, 1'b0, 1'b0}, {2'b10, 3'd4, 1'b1, 1'b0, 1'b1}, {2'b10, 3'd5, 1'b1, 1'b0, 1'b1},
             {2'b10, 3'd5, 1'b0, 1'b1, 1'b1}, {2'b00, 3'd0, 1'b0, 1'b0, 1'b0}, {2'b01, 3'd0, 1'b1, 1'b0, 1'b1}};
      req = 2'b11;
      lo[0] = 3'd0;
      hi[0] = 3'd1;
      lo[1] = 3'd4;
      hi[1] = 3'd5;
      pulse_reset();
      foreach (rr[i]) begin
        cyc();
        chk($sformatf("round_robin_%0d", i), rr[i]);
      end
      req = 2'b00;
      cyc();
    end

    pulse_reset();
    req = 2'b10;
    lo[1] = 3'd0;
    hi[1] = 3'd7;
    cyc();
    chk("abort_grant", {2'b10, 3'd0, 1'b1, 1'b0, 1'b1});
    cyc();
    chk("abort_second", {2'b10, 3'd1, 1'b1, 1'b0, 1'b1});
    req = 2'b00;
    cyc();
    chk("abort_idle", '0);
    cyc();
    chk("abort_no_done", '0);
    req = 2'b11;
    lo[0] = 3'd3;
    hi[0] = 3'd3;
    cyc();
    chk("abort_ptr_kept", {2'b01, 3'd3, 1'b1, 1'b0, 1'b1});
    req = 2'b00;
    cyc();

    pulse_reset();
    req = 2'b01;
    lo[0] = 3'd2;
    hi[0] = 3'd4;
    cyc();
    cyc();
    chk("midrun_before_reset", {2'b01, 3'd3, 1'b1, 1'b0, 1'b1});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", '0);
    req = 2'b11;
    lo[1] = 3'd6;
    @(negedge clk);
    chk("held_in_reset", '0);
    rst_n = 1'b1;
    cyc();
    chk("ptr_cleared_by_reset", {2'b01, 3'd2, 1'b1, 1'b0, 1'b1});
    req = 2'b00;
    cyc();

    // randomized requesters honouring the handshake: hold until done, drop the cycle after
    req = 2'b00;
    pulse_reset();
    q.delete();
    mptr = 0;
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (cur.d && cur.g[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          lo[i] = 3'($urandom);
          hi[i] = 3'($urandom);
        end else if ($urandom_range(0, 3) == 0) begin
          lo[i] = 3'($urandom);
          hi[i] = 3'($urandom);
        end
      end
      model_step();
      cyc();
      chk("random", cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_run_arbiter.md
# count_run_arbiter

Controller that shares one small up-counter datapath between several requesters. Each requester asks for a counting run over its own inclusive value range `[lo, hi]`. The block arbitrates round-robin, latches the winner's range, steps the count one value per clock, and signals completion with a one-cycle `done` pulse. It sits in front of the 3-bit count-sequence logic and replaces hard-coded sequences such as 2→3→4 with requester-programmed runs.

## Interface
- `WIDTH`, default 3: count width in bits. Arithmetic is modulo 2^WIDTH.
- `NREQ`, default 2: number of requesters. Must be ≥2.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input NREQ: per-requester run request. Level signal, held high until `done` is seen.
- `lo` input NREQ×WIDTH: per-requester start value. Sampled only at grant.
- `hi` input NREQ×WIDTH: per-requester end value. Sampled only at grant.
- `gnt` output NREQ: one-hot grant to the requester that owns the current run. All zero when idle.
- `out` output WIDTH: current count value.
- `out_valid` output 1: `out` is a valid run value this cycle.
- `done` output 1: one-cycle pulse after the last value of a completed run.
- `busy` output 1: high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset value of every output is 0: `gnt`, `out`, `out_valid`, `done` and `busy` all clear. The round-robin pointer resets to 0, so requester 0 has highest priority first.
- IDLE:
  - If any `req` bit is high, pick the winner, latch `lo[i]` and `hi[i]`, and go to RUN.
  - The winner is the first requester with `req` high, searching from the pointer upward and wrapping.
  - On grant, pointer becomes `(i+1) mod NREQ`.
- RUN:
  - `out` starts at the latched `lo` and increments by 1 per cycle, modulo 2^WIDTH.
  - On the edge where `out == hi_latched`, go to DONE.
  - If `req[i]` of the owner is sampled low, abort: go to IDLE next edge with no `done` pulse.
  - Changes on `lo`/`hi` during a run are ignored.
- DONE:
  - `done` = 1, `out_valid` = 0, `out` holds `hi`, `gnt` still asserted.
  - Next edge goes unconditionally to IDLE.
- Run length is `((hi - lo) mod 2^WIDTH) + 1` valid cycles.
  - `lo == hi`: one valid cycle.
  - `lo > hi`: run wraps through max and 0, e.g. 6,7,0,1.
  - `lo = hi+1`: full 2^WIDTH-value run.
- Handshake: the requester drops `req` the cycle after it sees `done`. A `req` still high when the block is back in IDLE is treated as a new request.
- Requests from non-owners during RUN/DONE are held pending, not lost, provided they stay asserted.

## Timing
- Grant latency: `req` high sampled in IDLE at edge E0 → after E0, `gnt[i]`=1, `out`=lo, `out_valid`=1, `busy`=1.
- Values `lo`, `lo+1`, … appear after edges E0, E0+1, …; `hi` appears after edge E0+L−1, where L is the run length.
- After edge E0+L: DONE (`done`=1).
- After edge E0+L+1: IDLE (`gnt`=0, `busy`=0).
- Earliest next grant is at edge E0+L+2.
- Abort: owner `req` low sampled at edge Ea → after Ea, IDLE with all outputs 0. The pointer keeps its post-grant value.
- Asserting `rst_n` low mid-run clears all state and outputs immediately, without waiting for a clock edge. The first grant after release follows the normal latency.
- Outputs are registered; there are no combinational paths from `req`/`lo`/`hi` to outputs.

## Structure
- Package `count_ctrl_pkg`:
  - `state_t` enum {IDLE, RUN, DONE}.
  - `COUNT_W` = 3 as the default for `WIDTH`.
- Sub-module `rr_arbiter`:
  - Parameter `NREQ`.
  - Inputs: `clk`, `rst_n`, `req`, `advance`.
  - Outputs: one-hot `pick` (combinational) and the registered pointer.
  - `advance` is pulsed by the FSM on grant.
- The top level holds the FSM, range latches and counter register.

## Test plan
- Reset: `rst_n`=0 with `req`=2'b11 → all outputs 0. After release, `req[0]` wins first (`gnt`=2'b01).
- Basic run: `req[0]` with `lo`=2, `hi`=4 → `out` 2,3,4 with `out_valid`=1; then `done`=1 for one cycle; `gnt` drops one cycle later.
- Wrap and single value:
  - `lo`=6, `hi`=1 → 6,7,0,1, then `done`.
  - `lo`=hi=5 → one valid cycle of 5, then `done`.
- Round-robin: `req`=2'b11 held throughout → grants alternate 01,10,01. Each run is complete, with ranges latched at grant.
- Abort and mid-run reset:
  - `req[1]` dropped after the 2nd value of 0..7 → IDLE next cycle, no `done`.
  - `rst_n` pulsed low mid-run → immediate all-zero outputs, pointer back to 0.
- Range change during run: `hi` changed from 4 to 7 after grant → run still ends at 4.
